// File: rtl/counter_job_arbiter.sv
// rtl/counter_job_arbiter.sv - round-robin arbiter sharing one up/down job counter between two requesters
module counter_job_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       dir,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [1:0]       gnt_d;
    logic [1:0]       done_d;
    logic             busy_d;
    logic [WIDTH-1:0] count_d;

    // job context captured at grant so later input changes cannot disturb a running job
    logic             owner, owner_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             prio, prio_d;

    logic             winner;
    logic [WIDTH-1:0] terminal;
    logic             owner_req;

    // state and every output register; reset clears everything and favours requester 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
            done  <= 2'b00;
            busy  <= 1'b0;
            count <= '0;
            owner <= 1'b0;
            dir_q <= 1'b0;
            len_q <= '0;
            prio  <= 1'b0;
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            done  <= done_d;
            busy  <= busy_d;
            count <= count_d;
            owner <= owner_d;
            dir_q <= dir_d;
            len_q <= len_d;
            prio  <= prio_d;
        end
    end

    // arbitration winner, terminal value and the owner's live request
    always_comb begin
        winner = 1'b0;
        if (req == 2'b10) begin
            winner = 1'b1;
        end else if (req == 2'b11) begin
            winner = prio;
        end
        terminal  = dir_q ? len_q : '0;
        owner_req = req[owner];
    end

    // next-state and next-output logic; an abort still lets the counter take its step on that edge
    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        done_d  = 2'b00;
        busy_d  = busy;
        count_d = count;
        owner_d = owner;
        dir_d   = dir_q;
        len_d   = len_q;
        prio_d  = prio;

        case (state)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = winner;
                    dir_d   = dir[winner];
                    len_d   = winner ? len1 : len0;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                count_d = dir_q ? '0 : len_q;
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    prio_d  = ~owner;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (count != terminal) begin
                    count_d = dir_q ? (count + WIDTH'(1)) : (count - WIDTH'(1));
                end
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    prio_d  = ~owner;
                end else if (count == terminal) begin
                    state_d = ST_DONE;
                    done_d  = owner ? 2'b10 : 2'b01;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                prio_d  = ~owner;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_job_arbiter.sv
// tb/tb_counter_job_arbiter.sv - directed self-checking bench for counter_job_arbiter
module tb_counter_job_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] dir;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] count;
    logic [1:0] done;

    int tests_run;
    int tests_failed;

    counter_job_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dir   (dir),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // one complete job, checked cycle by cycle; inputs are scrambled after grant and restored at the end
    task automatic run_job(input string tag, input int who, input int up, input int len);
        logic [1:0] sv_dir;
        logic [3:0] sv_len0;
        logic [3:0] sv_len1;
        int exp_gnt;
        exp_gnt = (who == 1) ? 2 : 1;
        step();
        check({tag, ".gnt"}, 32'(gnt), exp_gnt);
        check({tag, ".busy"}, 32'(busy), 1);
        sv_dir  = dir;
        sv_len0 = len0;
        sv_len1 = len1;
        dir  = ~dir;
        len0 = ~len0;
        len1 = ~len1;
        step();
        check({tag, ".load"}, 32'(count), (up != 0) ? 0 : len);
        for (int i = 1; i <= len; i++) begin
            step();
            check({tag, ".run"}, 32'(count), (up != 0) ? i : (len - i));
            check({tag, ".nodone"}, 32'(done), 0);
        end
        step();
        check({tag, ".done"}, 32'(done), exp_gnt);
        check({tag, ".final"}, 32'(count), (up != 0) ? len : 0);
        check({tag, ".gnt_done"}, 32'(gnt), exp_gnt);
        dir  = sv_dir;
        len0 = sv_len0;
        len1 = sv_len1;
        step();
        check({tag, ".done_clr"}, 32'(done), 0);
        check({tag, ".gnt_clr"}, 32'(gnt), 0);
        check({tag, ".idle"}, 32'(busy), 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst  = 1'b0;
        req  = 2'b11;
        dir  = 2'b00;
        len0 = 4'd0;
        len1 = 4'd0;

        // reset with both requesting
        step();
        step();
        check("rst.gnt", 32'(gnt), 0);
        check("rst.done", 32'(done), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.count", 32'(count), 0);
        rst = 1'b1;
        step();
        check("rst.first_gnt", 32'(gnt), 1);

        // requester 0, up, length 3
        req = 2'b00;
        do_reset();
        req  = 2'b01;
        dir  = 2'b01;
        len0 = 4'd3;
        run_job("up3", 0, 1, 3);
        req = 2'b00;
        step();
        check("up3.hold", 32'(count), 3);

        // requester 1, down, length 5
        req  = 2'b10;
        dir  = 2'b00;
        len1 = 4'd5;
        run_job("dn5", 1, 0, 5);
        req = 2'b00;
        step();
        check("dn5.hold", 32'(count), 0);
        check("dn5.busy", 32'(busy), 0);

        // both held: grants alternate with a one-cycle gap
        do_reset();
        req  = 2'b11;
        dir  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd2;
        run_job("alt_a", 0, 1, 2);
        run_job("alt_b", 1, 1, 2);
        run_job("alt_c", 0, 1, 2);
        req = 2'b00;
        step();

        // zero-length up job and max-length down job
        do_reset();
        req  = 2'b01;
        dir  = 2'b01;
        len0 = 4'd0;
        run_job("up0", 0, 1, 0);
        req = 2'b00;
        step();
        req  = 2'b01;
        dir  = 2'b00;
        len0 = 4'd15;
        run_job("dn15", 0, 0, 15);
        req = 2'b00;
        step();

        // max-length up job ends on all-ones
        req  = 2'b01;
        dir  = 2'b01;
        len0 = 4'd15;
        run_job("up15", 0, 1, 15);
        req = 2'b00;
        step();

        // abort mid-run: the step on the abort edge is kept, no done, prio advances
        do_reset();
        req  = 2'b01;
        dir  = 2'b01;
        len0 = 4'd7;
        step();
        step();
        step();
        step();
        check("abort.pre", 32'(count), 2);
        req = 2'b00;
        step();
        check("abort.count", 32'(count), 3);
        check("abort.gnt", 32'(gnt), 0);
        check("abort.busy", 32'(busy), 0);
        check("abort.done", 32'(done), 0);
        step();
        check("abort.hold", 32'(count), 3);
        check("abort.nodone", 32'(done), 0);
        req  = 2'b11;
        dir  = 2'b11;
        len1 = 4'd9;
        step();
        check("abort.prio", 32'(gnt), 2);

        // asynchronous reset mid-run
        step();
        step();
        step();
        check("arst.pre", 32'(count), 2);
        #3;
        rst = 1'b0;
        #1;
        check("arst.gnt", 32'(gnt), 0);
        check("arst.busy", 32'(busy), 0);
        check("arst.count", 32'(count), 0);
        check("arst.done", 32'(done), 0);
        req = 2'b00;
        step();
        rst = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
